// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions for the fetch stage: word width, bubble word,
// HALT opcode and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam int XLEN = 16;

  localparam logic [XLEN-1:0] NOP_WORD_DEFAULT = 16'h0800;
  localparam logic [4:0]      HALT_OPCODE      = 5'b00000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [XLEN-1:0] word);
    return word[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// One-entry skid buffer that parks a fetched word (and its pc+2) while decode
// is stalled. Clear wins over load, load wins over drain.
module fetch_skid_buf
  import instr_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] load_word,
  input  logic [XLEN-1:0] load_pc2,
  output logic            full,
  output logic [XLEN-1:0] word,
  output logic [XLEN-1:0] pc2
);

  logic            full_reg;
  logic [XLEN-1:0] word_reg;
  logic [XLEN-1:0] pc2_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_reg <= 1'b0;
      word_reg <= '0;
      pc2_reg  <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (load) begin
      full_reg <= 1'b1;
      word_reg <= load_word;
      pc2_reg  <= load_pc2;
    end else if (drain) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign word = word_reg;
  assign pc2  = pc2_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// one-entry output register to decode, skid buffer for stalls, redirect flush.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000,
  parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEFAULT
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_plus2,
  output logic            if_valid,
  output logic            id_HALT,
  output logic            err
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] out_word_reg, out_word_next;
  logic [XLEN-1:0] out_pc2_reg, out_pc2_next;
  logic            out_valid_reg, out_valid_next;
  logic            drop_reg, drop_next;
  logic            err_reg, err_next;

  logic            skid_load, skid_drain, skid_clear, skid_full;
  logic [XLEN-1:0] skid_word, skid_pc2;
  logic            req_fire;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (skid_clear),
    .load_word (imem_rdata),
    .load_pc2  (pc_reg + 16'd2),
    .full      (skid_full),
    .word      (skid_word),
    .pc2       (skid_pc2)
  );

  // A pending drop means the old request is still in flight, so the new one waits.
  assign imem_req  = (state_reg == REQ) && !drop_reg && !skid_full;
  assign imem_addr = pc_reg;
  assign req_fire  = imem_req && imem_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      out_word_reg  <= NOP_WORD;
      out_pc2_reg   <= RESET_PC + 16'd2;
      out_valid_reg <= 1'b0;
      drop_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      out_word_reg  <= out_word_next;
      out_pc2_reg   <= out_pc2_next;
      out_valid_reg <= out_valid_next;
      drop_reg      <= drop_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    out_word_next  = out_word_reg;
    out_pc2_next   = out_pc2_reg;
    out_valid_next = out_valid_reg;
    drop_next      = drop_reg;
    err_next       = err_reg;
    skid_load      = 1'b0;
    skid_drain     = 1'b0;
    skid_clear     = 1'b0;

    if (redirect) begin
      pc_next        = redirect_pc;
      skid_clear     = 1'b1;
      out_word_next  = NOP_WORD;
      out_valid_next = 1'b0;
      state_next     = REQ;
      // Any response still owed by memory must be thrown away when it lands.
      drop_next      = (((state_reg == WAIT) || drop_reg) && !imem_rvalid) || req_fire;
      if (redirect_pc[0]) begin
        err_next = 1'b1;
      end
    end else begin
      if (!stall) begin
        if (skid_full) begin
          out_word_next  = skid_word;
          out_pc2_next   = skid_pc2;
          out_valid_next = 1'b1;
          pc_next        = skid_pc2;
          skid_drain     = 1'b1;
          if (is_halt(skid_word)) begin
            state_next = HALTED;
          end
        end else if (state_reg != HALTED) begin
          out_word_next  = NOP_WORD;
          out_valid_next = 1'b0;
        end
      end

      case (state_reg)
        IDLE: state_next = REQ;
        REQ: begin
          if (drop_reg) begin
            if (imem_rvalid) begin
              drop_next = 1'b0;
            end
          end else if (req_fire) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_next = REQ;
            if (stall) begin
              skid_load = 1'b1;
            end else begin
              out_word_next  = imem_rdata;
              out_pc2_next   = pc_reg + 16'd2;
              out_valid_next = 1'b1;
              pc_next        = pc_reg + 16'd2;
              if (is_halt(imem_rdata)) begin
                state_next = HALTED;
              end
            end
          end
        end
        HALTED: state_next = HALTED;
        default: state_next = IDLE;
      endcase
    end
  end

  assign instruction = out_word_reg;
  assign pc_plus2    = out_pc2_reg;
  assign if_valid    = out_valid_reg;
  assign id_HALT     = out_valid_reg && is_halt(out_word_reg);
  assign err         = err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed phases push expected words,
// a monitor pops and compares each word accepted by decode.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instruction;
  logic [15:0] pc_plus2;
  logic        if_valid;
  logic        id_HALT;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc2;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] grant_log[$];

  int          latency = 1;
  logic [15:0] halt_addr = 16'h0001;
  logic [15:0] data_xor = 16'h0000;
  logic        mem_pending = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_data = 16'h0000;
  logic        held_halt = 1'b0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(16'h0000), .NOP_WORD(16'h0800)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_plus2    (pc_plus2),
    .if_valid    (if_valid),
    .id_HALT     (id_HALT),
    .err         (err)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    if (a == 16'h0000)  return 16'h4000;
    if (a == 16'h0002)  return 16'h4800;
    return {1'b1, a[15:1]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] w, input logic [15:0] p);
    exp_t e;
    e.word = w;
    e.pc2  = p;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic sample();
    #3;
  endtask

  // Memory model: one slot, response 'latency' cycles after the grant edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (mem_pending) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_data;
          mem_pending = 1'b0;
        end
      end
      if (imem_req && imem_gnt) begin
        check1("one_outstanding", mem_pending, 1'b0);
        mem_pending = 1'b1;
        mem_cnt     = latency;
        mem_data    = mem_word(imem_addr) ^ data_xor;
        grant_log.push_back(imem_addr);
      end
    end
  end

  // Monitor: decode accepts a valid word in every cycle without stall.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        held_halt = 1'b0;
      end else if (!if_valid) begin
        held_halt = 1'b0;
        check("bubble_word", instruction, 16'h0800);
        check1("bubble_halt", id_HALT, 1'b0);
      end else if (!stall && !held_halt) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h pc2 %h want none", instruction, pc_plus2);
        end else begin
          e = sb_q.pop_front();
          check("sb_word", instruction, e.word);
          check("sb_pc2", pc_plus2, e.pc2);
          check1("sb_halt", id_HALT, e.word[15:11] == 5'b00000);
          $display("accept word=%h pc2=%h halt=%b", instruction, pc_plus2, id_HALT);
        end
        if (id_HALT) held_halt = 1'b1;
      end
    end
  end

  task automatic do_reset();
    step();
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    sample();
    step();
    sample();
    check1("reset_req", imem_req, 1'b0);
    check("reset_addr", imem_addr, 16'h0000);
    check("reset_instr", instruction, 16'h0800);
    check("reset_pc2", pc_plus2, 16'h0002);
    check1("reset_valid", if_valid, 1'b0);
    check1("reset_halt", id_HALT, 1'b0);
    check1("reset_err", err, 1'b0);
    step();
    rst = 1'b1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 100; i++) begin
      step();
      sample();
      if (imem_req) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_req: timed out, imem_req got 0 want 1");
  endtask

  task automatic wait_rvalid();
    for (int i = 0; i < 100; i++) begin
      step();
      sample();
      if (imem_rvalid) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_rvalid: timed out, imem_rvalid got 0 want 1");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      step();
      sample();
      if (sb_q.size() == 0 && id_HALT) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_done: timed out with %0d words outstanding, want 0 and HALT", sb_q.size());
    sb_q.delete();
  endtask

  task automatic check_grants(input string name, input logic [15:0] a0, input logic [15:0] a1);
    if (grant_log.size() >= 2) begin
      check(name, grant_log[0], a0);
      check(name, grant_log[1], a1);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d grants want at least 2", name, grant_log.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic fetch, latency 1, then HALT and resume via redirect.
    latency = 1;
    halt_addr = 16'h0004;
    grant_log.delete();
    do_reset();
    expect_word(16'h4000, 16'h0002);
    expect_word(16'h4800, 16'h0004);
    expect_word(16'h0000, 16'h0006);
    wait_rvalid();
    step();
    sample();
    check("first_instr", instruction, 16'h4000);
    check("first_pc2", pc_plus2, 16'h0002);
    check1("first_valid", if_valid, 1'b1);
    wait_done();
    check_grants("basic_addr", 16'h0000, 16'h0002);
    for (int i = 0; i < 10; i++) begin
      step();
      sample();
      check1("halted_req", imem_req, 1'b0);
      check1("halted_flag", id_HALT, 1'b1);
    end
    expect_word(16'h8010, 16'h0022);
    expect_word(16'h0000, 16'h0024);
    halt_addr = 16'h0022;
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    wait_done();

    // Stall while a response arrives: skid buffer holds it.
    latency = 2;
    halt_addr = 16'h0006;
    do_reset();
    expect_word(16'h4000, 16'h0002);
    expect_word(16'h4800, 16'h0004);
    expect_word(16'h8002, 16'h0006);
    expect_word(16'h0000, 16'h0008);
    wait_rvalid();
    for (int k = 1; k <= 4; k++) begin
      step();
      stall = 1'b1;
      sample();
      check("stall_hold", instruction, 16'h4000);
      check1("stall_valid", if_valid, 1'b1);
      if (k == 4) check1("skid_blocks_req", imem_req, 1'b0);
    end
    step();
    stall = 1'b0;
    sample();
    check1("skid_blocks_req2", imem_req, 1'b0);
    check("stall_release", instruction, 16'h4000);
    step();
    sample();
    check("skid_drain", instruction, 16'h4800);
    check("skid_drain_pc2", pc_plus2, 16'h0004);
    wait_done();

    // Redirect while waiting, latency 3: stale word dropped.
    latency = 3;
    halt_addr = 16'h0104;
    do_reset();
    expect_word(16'h8080, 16'h0102);
    expect_word(16'h8081, 16'h0104);
    expect_word(16'h0000, 16'h0106);
    wait_req();
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    sample();
    step();
    redirect = 1'b0;
    sample();
    check("redir_addr", imem_addr, 16'h0100);
    check1("redir_drop_req", imem_req, 1'b0);
    check1("redir_bubble", if_valid, 1'b0);
    check("redir_nop", instruction, 16'h0800);
    step();
    sample();
    check1("redir_drop_req2", imem_req, 1'b0);
    step();
    sample();
    check1("redir_new_req", imem_req, 1'b1);
    check("redir_new_addr", imem_addr, 16'h0100);
    wait_done();

    // Redirect in the same cycle as rvalid.
    latency = 1;
    halt_addr = 16'h0202;
    do_reset();
    expect_word(16'h8100, 16'h0202);
    expect_word(16'h0000, 16'h0204);
    wait_req();
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    sample();
    step();
    redirect = 1'b0;
    sample();
    check1("same_cycle_valid", if_valid, 1'b0);
    check("same_cycle_addr", imem_addr, 16'h0200);
    check1("same_cycle_req", imem_req, 1'b1);
    wait_done();

    // Misaligned redirect sets sticky err.
    expect_word(16'h0000, 16'h0013);
    halt_addr = 16'h0011;
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0011;
    step();
    redirect = 1'b0;
    sample();
    check1("err_set", err, 1'b1);
    wait_done();
    check1("err_sticky", err, 1'b1);

    // PC wrap from 0xFFFE to 0x0000.
    expect_word(16'hFFFF, 16'h0000);
    expect_word(16'h0000, 16'h0002);
    halt_addr = 16'h0000;
    grant_log.delete();
    step();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    wait_done();
    check_grants("wrap_addr", 16'hFFFE, 16'h0000);
    check1("err_still", err, 1'b1);

    // Reset mid-transaction: the abandoned response is ignored.
    latency = 3;
    halt_addr = 16'h0002;
    data_xor = 16'h00FF;
    do_reset();
    expect_word(16'h4000, 16'h0002);
    expect_word(16'h0000, 16'h0004);
    wait_req();
    step();
    rst = 1'b0;
    data_xor = 16'h0000;
    sample();
    check1("midreset_req", imem_req, 1'b0);
    check1("midreset_valid", if_valid, 1'b0);
    check1("midreset_err", err, 1'b0);
    step();
    rst = 1'b1;
    wait_done();

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
